mult_share_arb: RTL

Round-robin arbiter and two-stage pipeline that shares one unsigned 25x18 `multiplier` instance among NREQ requesters. Each requester presents operands with a valid/ready handshake. The block registers the winning operands, multiplies them, and returns a 48-bit product tagged with the requester index through a single valid/ready result port with full backpressure. It sits between the CGRA processing elements and the DSP48E_custom multiply datapath.

---
 rtl/multiplier.sv | 18 +
 rtl/mult_share_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// Unsigned combinational multiplier shared by the arbiter pipeline.
// The product is zero-extended to the full output width.
module multiplier #(
  parameter int unsigned AW = 25,
  parameter int unsigned BW = 18,
  parameter int unsigned PW = 48
) (
  input  logic [AW-1:0] A_MULT,
  input  logic [BW-1:0] B,
  output logic [PW-1:0] P
);

  // Widen both operands first so the product is computed at full width.
  always_comb begin
    P = PW'(A_MULT) * PW'(B);
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter feeding a two-stage multiply pipeline.
// S1 registers the winning operands, S2 registers the tagged product.
// Both stages advance together, so one product per cycle is sustained
// while the result port is ready, and at most two ops are in flight.
module mult_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]    REQ_VALID,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic [NREQ*25-1:0] REQ_A,
  input  logic [NREQ*18-1:0] REQ_B,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [47:0]       RES_DATA,
  output logic [IDW-1:0]    RES_ID,
  output logic              BUSY,
  output logic [15:0]       OP_COUNT
);

  localparam int unsigned AW = 25;
  localparam int unsigned BW = 18;
  localparam int unsigned PW = 48;

  // Pointer and pipeline state.
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1_valid_q;
  logic [AW-1:0]  s1_a_q;
  logic [BW-1:0]  s1_b_q;
  logic [IDW-1:0] s1_id_q;
  logic           res_valid_q;
  logic [PW-1:0]  res_data_q;
  logic [IDW-1:0] res_id_q;
  logic [15:0]    op_count_q;

  // Handshake and arbitration signals.
  logic           s2_free;
  logic           s1_free;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic           accept;
  logic [AW-1:0]  sel_a;
  logic [BW-1:0]  sel_b;
  logic [PW-1:0]  product;
  logic           res_fire;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s2_free  = !res_valid_q || RES_READY;
    s1_free  = !s1_valid_q || s2_free;
    res_fire = res_valid_q && RES_READY;
  end

  // First valid requester searching from ptr upward, wrapping at NREQ.
  // cand is one bit wider than the index so ptr+i never overflows.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!gnt_any && REQ_VALID[cand[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // Grant is suppressed during reset so nothing is accepted and then lost.
  always_comb begin
    accept    = gnt_any && s1_free && !RST;
    REQ_READY = '0;
    if (accept) begin
      REQ_READY[gnt_idx] = 1'b1;
    end
  end

  // Operand mux selecting the granted requester's A and B fields.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = REQ_A[AW*i +: AW];
        sel_b = REQ_B[BW*i +: BW];
      end
    end
  end

  // Next pointer: one past the winner, wrapping to zero after NREQ-1.
  always_comb begin
    if (gnt_idx == IDW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + IDW'(1);
    end
  end

  multiplier #(
    .AW (AW),
    .BW (BW),
    .PW (PW)
  ) u_mult (
    .A_MULT (s1_a_q),
    .B      (s1_b_q),
    .P      (product)
  );

  // Round-robin pointer moves only on an actual grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_d;
    end
  end

  // S1 operand register: load on grant, empty when drained, else hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= sel_a;
      s1_b_q     <= sel_b;
      s1_id_q    <= gnt_idx;
    end else if (s2_free) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2 result register; data and id only change when a new product lands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else if (s2_free) begin
      res_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_data_q <= product;
        res_id_q   <= s1_id_q;
      end
    end
  end

  // Completed result handshakes, wrapping naturally at 16 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_count_q <= '0;
    end else if (res_fire) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  // Outputs driven from registered state.
  always_comb begin
    RES_VALID = res_valid_q;
    RES_DATA  = res_data_q;
    RES_ID    = res_id_q;
    BUSY      = s1_valid_q || res_valid_q;
    OP_COUNT  = op_count_q;
  end

endmodule
